lagarto_dcache_req_queue: RTL

Parametrised load/store request queue between the Lagarto memory stage and the L1 data cache subsystem. Buffers up to DEPTH in-order memory requests and translates the head entry through the DTLB/MMU. Issues the translated request on a split load/store cache port with byte-enable and data alignment, and returns aligned load data to the core. Adds what the single-request interface lacks: multiple outstanding entries, ready/valid backpressure on both sides, misalignment detection, and kill with in-flight response draining.

---
 rtl/lagarto_dcache_req_queue_if.sv | 78 +++++++
 rtl/lagarto_dcache_req_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_dcache_req_queue_if.sv
// Request-queue bus bundle: core request side, MMU/DTLB side
// and the split load/store L1 data cache port.
interface lagarto_dcache_req_queue_if #(
    parameter int DEPTH   = 4,
    parameter int VADDR_W = 64,
    parameter int PADDR_W = 56,
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               req_valid_i;
    logic               req_ready_o;
    logic               req_is_load_i;
    logic [VADDR_W-1:0] req_vaddr_i;
    logic [63:0]        req_wdata_i;
    logic [1:0]         req_size_i;
    logic               kill_i;

    logic               mmu_req_o;
    logic               mmu_load_o;
    logic               mmu_store_o;
    logic [VADDR_W-1:0] mmu_vaddr_o;
    logic               dtlb_hit_i;
    logic [PADDR_W-1:0] paddr_i;

    logic               ld_req_valid_o;
    logic               ld_req_ready_i;
    logic [INDEX_W-1:0] ld_addr_index_o;
    logic [TAG_W-1:0]   ld_addr_tag_o;
    logic [7:0]         ld_be_o;
    logic [1:0]         ld_size_o;
    logic               ld_resp_valid_i;
    logic [63:0]        ld_resp_data_i;

    logic               st_req_valid_o;
    logic               st_req_ready_i;
    logic [INDEX_W-1:0] st_addr_index_o;
    logic [TAG_W-1:0]   st_addr_tag_o;
    logic [63:0]        st_wdata_o;
    logic [7:0]         st_be_o;
    logic [1:0]         st_size_o;

    logic               resp_valid_o;
    logic [63:0]        resp_data_o;
    logic               misaligned_o;
    logic [CNT_W-1:0]   count_o;

    modport slave (
        input  req_valid_i, req_is_load_i, req_vaddr_i,
        input  req_wdata_i, req_size_i, kill_i,
        input  dtlb_hit_i, paddr_i,
        input  ld_req_ready_i, ld_resp_valid_i, ld_resp_data_i,
        input  st_req_ready_i,
        output req_ready_o,
        output mmu_req_o, mmu_load_o, mmu_store_o, mmu_vaddr_o,
        output ld_req_valid_o, ld_addr_index_o, ld_addr_tag_o,
        output ld_be_o, ld_size_o,
        output st_req_valid_o, st_addr_index_o, st_addr_tag_o,
        output st_wdata_o, st_be_o, st_size_o,
        output resp_valid_o, resp_data_o, misaligned_o, count_o
    );

    modport master (
        output req_valid_i, req_is_load_i, req_vaddr_i,
        output req_wdata_i, req_size_i, kill_i,
        output dtlb_hit_i, paddr_i,
        output ld_req_ready_i, ld_resp_valid_i, ld_resp_data_i,
        output st_req_ready_i,
        input  req_ready_o,
        input  mmu_req_o, mmu_load_o, mmu_store_o, mmu_vaddr_o,
        input  ld_req_valid_o, ld_addr_index_o, ld_addr_tag_o,
        input  ld_be_o, ld_size_o,
        input  st_req_valid_o, st_addr_index_o, st_addr_tag_o,
        input  st_wdata_o, st_be_o, st_size_o,
        input  resp_valid_o, resp_data_o, misaligned_o, count_o
    );
endinterface

// File: rtl/lagarto_dcache_req_queue.sv
// In-order load/store request queue feeding the L1 dcache.
// Head entry is translated, issued, and its load data aligned.
module lagarto_dcache_req_queue #(
    parameter int DEPTH   = 4,
    parameter int VADDR_W = 64,
    parameter int PADDR_W = 56,
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
) (
    input logic                        clk_i,
    input logic                        rstn_i,
    lagarto_dcache_req_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic               is_load;
        logic [VADDR_W-1:0] vaddr;
        logic [63:0]        wdata;
        logic [1:0]         size;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE, XLATE, ISSUE, WAIT_RESP, DRAIN
    } state_e;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    state_e             state_q, state_d;
    logic [PADDR_W-1:0] paddr_q;
    logic               rdy_en_q;
    logic               resp_valid_q;
    logic [63:0]        resp_data_q;

    entry_t      head;
    logic [2:0]  off;
    logic [2:0]  lo_mask;
    logic [7:0]  be_base;
    logic [7:0]  be;
    logic [63:0] size_mask;
    logic [63:0] ld_shift;
    logic        misaligned;

    logic push, pop;
    logic mmu_req, ld_v, st_v;
    logic latch_paddr, resp_fire, mis_pulse;

    assign head = mem_q[head_q];
    assign off  = head.vaddr[2:0];

    always_comb begin
        lo_mask   = 3'b000;
        be_base   = 8'h01;
        size_mask = 64'hFF;
        unique case (head.size)
            2'd0: begin
                lo_mask   = 3'b000;
                be_base   = 8'h01;
                size_mask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                lo_mask   = 3'b001;
                be_base   = 8'h03;
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                lo_mask   = 3'b011;
                be_base   = 8'h0F;
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                lo_mask   = 3'b111;
                be_base   = 8'hFF;
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    assign misaligned = |(off & lo_mask);
    assign be         = be_base << off;
    assign ld_shift   = bus.ld_resp_data_i >> {off, 3'b000};

    assign bus.req_ready_o = rdy_en_q
                           && (count_q < CNT_W'(DEPTH))
                           && !bus.kill_i;
    assign push = bus.req_valid_i && bus.req_ready_o;

    // IDLE already requests translation so an aligned head costs no bubble
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mis_pulse   = 1'b0;
        mmu_req     = 1'b0;
        ld_v        = 1'b0;
        st_v        = 1'b0;
        latch_paddr = 1'b0;
        resp_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !bus.kill_i) begin
                    if (misaligned) begin
                        pop       = 1'b1;
                        mis_pulse = 1'b1;
                    end else begin
                        mmu_req = 1'b1;
                        if (bus.dtlb_hit_i) begin
                            latch_paddr = 1'b1;
                            state_d     = ISSUE;
                        end else begin
                            state_d = XLATE;
                        end
                    end
                end
            end
            XLATE: begin
                mmu_req = 1'b1;
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else if (bus.dtlb_hit_i) begin
                    latch_paddr = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (head.is_load) begin
                    ld_v = 1'b1;
                    if (bus.ld_req_ready_i)
                        state_d = bus.kill_i ? DRAIN : WAIT_RESP;
                    else if (bus.kill_i)
                        state_d = IDLE;
                end else begin
                    st_v = 1'b1;
                    if (bus.st_req_ready_i) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else if (bus.kill_i) begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RESP: begin
                if (bus.ld_resp_valid_i) begin
                    state_d = IDLE;
                    if (!bus.kill_i) begin
                        pop       = 1'b1;
                        resp_fire = 1'b1;
                    end
                end else if (bus.kill_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.ld_resp_valid_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            paddr_q      <= '0;
            rdy_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            resp_valid_q <= resp_fire;
            if (resp_fire)
                resp_data_q <= ld_shift & size_mask;
            if (latch_paddr)
                paddr_q <= bus.paddr_i;
            if (push)
                tail_q <= tail_q + PTR_W'(1);
            if (bus.kill_i) begin
                count_q <= '0;
                head_q  <= tail_q;
            end else begin
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (pop)
                    head_q <= head_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= '{
                is_load: bus.req_is_load_i,
                vaddr:   bus.req_vaddr_i,
                wdata:   bus.req_wdata_i,
                size:    bus.req_size_i
            };
        end
    end

    assign bus.mmu_req_o   = mmu_req;
    assign bus.mmu_load_o  = mmu_req && head.is_load;
    assign bus.mmu_store_o = mmu_req && !head.is_load;
    assign bus.mmu_vaddr_o = mmu_req ? head.vaddr : '0;

    assign bus.ld_req_valid_o  = ld_v;
    assign bus.ld_addr_index_o = ld_v ? paddr_q[INDEX_W-1:0] : '0;
    assign bus.ld_addr_tag_o   = ld_v ? paddr_q[PADDR_W-1:INDEX_W] : '0;
    assign bus.ld_be_o         = ld_v ? be : '0;
    assign bus.ld_size_o       = ld_v ? head.size : '0;

    assign bus.st_req_valid_o  = st_v;
    assign bus.st_addr_index_o = st_v ? paddr_q[INDEX_W-1:0] : '0;
    assign bus.st_addr_tag_o   = st_v ? paddr_q[PADDR_W-1:INDEX_W] : '0;
    assign bus.st_wdata_o      = st_v ? head.wdata << {off, 3'b000} : '0;
    assign bus.st_be_o         = st_v ? be : '0;
    assign bus.st_size_o       = st_v ? head.size : '0;

    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.misaligned_o = mis_pulse;
    assign bus.count_o      = count_q;
endmodule
